alarm_clock_core: RTL and testbench

ALARM_CLOCK_CORE -- requirements
Module: alarm_clock_core

---
 rtl/alarm_clock_core.sv | 179 +++++++++++++++++
 tb/tb_alarm_clock_core.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_core.sv
// ============================================================================
// Module   : alarm_clock_core
// Purpose  : 24h time-of-day clock with N_ALARM ringing alarm channels.
// Options  : define ALARM_SNOOZE_EN to add the SNOOZE state and i_snooze.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_clock_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int N_ALARM    = 2,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_time_wr,
  input  logic               i_alarm_wr,
  input  logic [2:0]         i_alarm_sel,
  input  logic [4:0]         i_wr_hour,
  input  logic [5:0]         i_wr_min,
  input  logic [N_ALARM-1:0] i_alarm_en,
  input  logic               i_ack,
  input  logic               i_snooze,
  output logic [5:0]         o_sec,
  output logic [5:0]         o_min,
  output logic [4:0]         o_hour,
  output logic               o_tick,
  output logic [N_ALARM-1:0] o_alarm,
  output logic               o_alarm_any
);

  localparam int PW = $clog2(CLK_HZ);

`ifdef ALARM_SNOOZE_EN
  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RING = 2'd1, S_SNOOZE = 2'd2} state_t;
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RING = 1'b1} state_t;
  logic unused_snooze;
  assign unused_snooze = i_snooze;
`endif

  logic [PW-1:0] presc;
  logic [4:0]    al_hour [N_ALARM];
  logic [5:0]    al_min  [N_ALARM];

  logic       wr_ok, time_load, minute_edge, min_wrap;
  logic [5:0] nxt_min;
  logic [4:0] nxt_hour;

  assign o_tick      = (presc == PW'(CLK_HZ - 1));
  assign wr_ok       = (i_wr_hour <= 5'd23) && (i_wr_min <= 6'd59);
  assign time_load   = i_time_wr && wr_ok;
  // A loaded time never produces a match: the tick of that cycle is dropped.
  assign minute_edge = o_tick && !time_load && (o_sec == 6'd59);
  assign min_wrap    = (o_min == 6'd59);
  assign nxt_min     = min_wrap ? 6'd0 : o_min + 6'd1;
  assign nxt_hour    = !min_wrap ? o_hour : ((o_hour == 5'd23) ? 5'd0 : o_hour + 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      o_sec  <= 6'd0;
      o_min  <= 6'd0;
      o_hour <= 5'd0;
    end else if (time_load) begin
      presc  <= '0;
      o_sec  <= 6'd0;
      o_min  <= i_wr_min;
      o_hour <= i_wr_hour;
    end else begin
      presc <= o_tick ? '0 : presc + PW'(1);
      if (o_tick) begin
        if (o_sec == 6'd59) begin
          o_sec  <= 6'd0;
          o_min  <= nxt_min;
          o_hour <= nxt_hour;
        end else begin
          o_sec <= o_sec + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ALARM; i++) begin
        al_hour[i] <= 5'd0;
        al_min[i]  <= 6'd0;
      end
    end else if (i_alarm_wr && wr_ok) begin
      for (int i = 0; i < N_ALARM; i++) begin
        if (i_alarm_sel == 3'(i)) begin
          al_hour[i] <= i_wr_hour;
          al_min[i]  <= i_wr_min;
        end
      end
    end
  end

  for (genvar g = 0; g < N_ALARM; g++) begin : g_chan
    state_t     state;
    logic [7:0] ring_cnt;
    logic       ringing;
    logic       match;
`ifdef ALARM_SNOOZE_EN
    logic [11:0] snz_cnt;
`endif

    assign match      = minute_edge && i_alarm_en[g] &&
                        (nxt_min == al_min[g]) && (nxt_hour == al_hour[g]);
    assign o_alarm[g] = ringing;

    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= S_IDLE;
        ring_cnt <= 8'd0;
        ringing  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
        snz_cnt  <= 12'd0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (match) begin
              state    <= S_RING;
              ring_cnt <= 8'd0;
              ringing  <= 1'b1;
            end
          end
          S_RING: begin
            if (i_ack || !i_alarm_en[g]) begin
              state   <= S_IDLE;
              ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            end else if (i_snooze) begin
              state   <= S_SNOOZE;
              snz_cnt <= 12'd0;
              ringing <= 1'b0;
`endif
            end else if (o_tick) begin
              if (ring_cnt == 8'(RING_SEC - 1)) begin
                state   <= S_IDLE;
                ringing <= 1'b0;
              end else begin
                ring_cnt <= ring_cnt + 8'd1;
              end
            end
          end
`ifdef ALARM_SNOOZE_EN
          S_SNOOZE: begin
            if (i_ack || !i_alarm_en[g]) begin
              state <= S_IDLE;
            end else if (o_tick) begin
              if (snz_cnt == 12'(SNOOZE_TICKS - 1)) begin
                state    <= S_RING;
                ring_cnt <= 8'd0;
                ringing  <= 1'b1;
              end else begin
                snz_cnt <= snz_cnt + 12'd1;
              end
            end
          end
`endif
          default: begin
            state   <= S_IDLE;
            ringing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_alarm_any = |o_alarm;

endmodule

`default_nettype wire

// File: tb/tb_alarm_clock_core.sv
// ============================================================================
// Module   : tb_alarm_clock_core
// Purpose  : Self-checking bench for alarm_clock_core (seconds-of-day model).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_clock_core;

  localparam int CLK_HZ = 4;
  localparam int N      = 2;
  localparam int RS     = 3;
  localparam int SM     = 1;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, time_wr, alarm_wr, ack, snooze;
  logic [2:0]   alarm_sel;
  logic [4:0]   wr_hour;
  logic [5:0]   wr_min;
  logic [N-1:0] alarm_en;
  logic [5:0]   o_sec, o_min;
  logic [4:0]   o_hour;
  logic         o_tick, o_alarm_any;
  logic [N-1:0] o_alarm;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: time as seconds of day, alarms as minutes of day,
  // channel mode 0=idle 1=ring 2=snooze with a seconds-remaining countdown.
  int m_tsec, m_presc;
  int m_amin [N];
  int m_mode [N];
  int m_left [N];

  alarm_clock_core #(.CLK_HZ(CLK_HZ), .N_ALARM(N), .RING_SEC(RS), .SNOOZE_MIN(SM)) dut (
    .clk(clk), .rst(rst), .i_time_wr(time_wr), .i_alarm_wr(alarm_wr),
    .i_alarm_sel(alarm_sel), .i_wr_hour(wr_hour), .i_wr_min(wr_min),
    .i_alarm_en(alarm_en), .i_ack(ack), .i_snooze(snooze),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_tick(o_tick),
    .o_alarm(o_alarm), .o_alarm_any(o_alarm_any)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_alarm();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = (m_mode[i] == 1);
    return r;
  endfunction

  function automatic logic [16:0] exp_time();
    return {5'(m_tsec / 3600), 6'((m_tsec / 60) % 60), 6'(m_tsec % 60)};
  endfunction

  task automatic step();
    bit tick, ok;
    int nxt;
    if (rst) begin
      m_tsec = 0; m_presc = 0;
      for (int i = 0; i < N; i++) begin m_amin[i] = 0; m_mode[i] = 0; m_left[i] = 0; end
    end else begin
      tick = (m_presc == CLK_HZ - 1);
      ok   = (wr_hour < 24) && (wr_min < 60);
      nxt  = (m_tsec + 1) % 86400;
      for (int i = 0; i < N; i++) begin
        case (m_mode[i])
          0: if (tick && !(time_wr && ok) && (nxt % 60 == 0) && (nxt / 60 == m_amin[i]) && alarm_en[i]) begin
               m_mode[i] = 1; m_left[i] = RS;
             end
          1: begin
               if (ack || !alarm_en[i]) m_mode[i] = 0;
               else if (snooze && SNZ) begin m_mode[i] = 2; m_left[i] = SM * 60; end
               else if (tick) begin
                 m_left[i] = m_left[i] - 1;
                 if (m_left[i] == 0) m_mode[i] = 0;
               end
             end
          default: begin
               if (ack || !alarm_en[i]) m_mode[i] = 0;
               else if (tick) begin
                 m_left[i] = m_left[i] - 1;
                 if (m_left[i] == 0) begin m_mode[i] = 1; m_left[i] = RS; end
               end
             end
        endcase
      end
      if (time_wr && ok) begin
        m_tsec = int'(wr_hour) * 3600 + int'(wr_min) * 60; m_presc = 0;
      end else begin
        if (tick) m_tsec = nxt;
        m_presc = (m_presc + 1) % CLK_HZ;
      end
      if (alarm_wr && ok && int'(alarm_sel) < N) m_amin[int'(alarm_sel)] = int'(wr_hour) * 60 + int'(wr_min);
    end
    @(posedge clk); #1;
    time_wr = 0; alarm_wr = 0; ack = 0; snooze = 0;
  endtask

  task automatic run_to(input int h, input int m, input int s, input int maxc);
    int target = h * 3600 + m * 60 + s;
    int n = 0;
    while (m_tsec != target && n < maxc) begin step(); n++; end
    if (m_tsec != target) begin
      compared++; mismatched++;
      $display("FAIL run_to_timeout model_time=%0d required=%0d", m_tsec, target);
    end
  endtask

  task automatic load_time(input int h, input int m);
    time_wr = 1; wr_hour = 5'(h); wr_min = 6'(m); step();
  endtask

  task automatic load_alarm(input int sel, input int h, input int m);
    alarm_wr = 1; alarm_sel = 3'(sel); wr_hour = 5'(h); wr_min = 6'(m); step();
  endtask

  task automatic test_reset();
    rst = 1; step(); step();
    compared++;
    if ({o_hour, o_min, o_sec} !== 17'd0) begin
      mismatched++; $display("FAIL reset_time got=%h required=0", {o_hour, o_min, o_sec});
    end
    compared++;
    if (o_tick !== 1'b0 || o_alarm !== '0 || o_alarm_any !== 1'b0) begin
      mismatched++; $display("FAIL reset_flags got tick=%b alarm=%b any=%b required all 0", o_tick, o_alarm, o_alarm_any);
    end
  endtask

  task automatic test_prescale();
    rst = 1; step(); rst = 0;
    for (int k = 1; k <= 16; k++) begin
      compared++;
      if (o_tick !== ((k % 4) == 0)) begin
        mismatched++; $display("FAIL prescale_tick cycle=%0d got=%b required=%b", k, o_tick, (k % 4) == 0);
      end
      step();
    end
    compared++;
    if (o_sec !== 6'd4) begin mismatched++; $display("FAIL prescale_sec got=%0d required=4", o_sec); end
  endtask

  task automatic test_rollover();
    int nt = 0;
    load_time(23, 59);
    for (int k = 0; k < 240; k++) begin
      if (o_tick === 1'b1) nt++;
      step();
    end
    compared++;
    if ({o_hour, o_min, o_sec} !== 17'd0) begin
      mismatched++; $display("FAIL rollover_time got=%0d:%0d:%0d required=0:0:0", o_hour, o_min, o_sec);
    end
    compared++;
    if (nt != 60) begin mismatched++; $display("FAIL rollover_ticks got=%0d required=60", nt); end
  endtask

  task automatic test_alarm_ring();
    rst = 1; step(); rst = 0;
    load_alarm(1, 0, 1);
    alarm_en = 2'b10;
    load_time(0, 0);
    run_to(0, 1, 0, 400);
    compared++;
    if (o_alarm !== 2'b10 || o_alarm_any !== 1'b1 || {o_min, o_sec} !== {6'd1, 6'd0}) begin
      mismatched++; $display("FAIL ring_start got alarm=%b any=%b min=%0d sec=%0d required 10/1/1/0", o_alarm, o_alarm_any, o_min, o_sec);
    end
    run_to(0, 1, 2, 20);
    compared++;
    if (o_alarm !== 2'b10) begin mismatched++; $display("FAIL ring_hold got=%b required=10", o_alarm); end
    run_to(0, 1, 3, 20);
    compared++;
    if (o_alarm !== 2'b00 || o_alarm_any !== 1'b0) begin
      mismatched++; $display("FAIL ring_autostop got=%b any=%b required=00/0", o_alarm, o_alarm_any);
    end
  endtask

  task automatic test_snooze();
    load_time(0, 0);
    run_to(0, 1, 0, 400);
    snooze = 1; step();
    compared++;
    if (o_alarm !== (SNZ ? 2'b00 : 2'b10)) begin
      mismatched++; $display("FAIL snooze_enter got=%b required=%b", o_alarm, SNZ ? 2'b00 : 2'b10);
    end
    run_to(0, 1, 59, 400);
    compared++;
    if (o_alarm !== 2'b00) begin mismatched++; $display("FAIL snooze_wait got=%b required=00", o_alarm); end
    run_to(0, 2, 0, 20);
    compared++;
    if (o_alarm !== (SNZ ? 2'b10 : 2'b00)) begin
      mismatched++; $display("FAIL snooze_rering got=%b required=%b", o_alarm, SNZ ? 2'b10 : 2'b00);
    end
    ack = 1; step();
    compared++;
    if (o_alarm !== 2'b00) begin mismatched++; $display("FAIL snooze_ack got=%b required=00", o_alarm); end
  endtask

  task automatic test_ack_snooze();
    load_time(0, 0);
    run_to(0, 1, 0, 400);
    ack = 1; snooze = 1; step();
    compared++;
    if (o_alarm !== 2'b00) begin mismatched++; $display("FAIL ack_wins got=%b required=00", o_alarm); end
    run_to(0, 2, 1, 400);
    compared++;
    if (o_alarm !== 2'b00) begin mismatched++; $display("FAIL ack_no_rering got=%b required=00", o_alarm); end
    load_time(24, 5);
    compared++;
    if ({o_hour, o_min, o_sec} !== {5'd0, 6'd2, 6'd1}) begin
      mismatched++; $display("FAIL bad_time_wr got=%0d:%0d:%0d required=0:2:1", o_hour, o_min, o_sec);
    end
    load_alarm(0, 0, 60);
    load_alarm(3, 0, 2);
    compared++;
    if (m_amin[0] != 0 || exp_alarm() !== o_alarm) begin
      mismatched++; $display("FAIL bad_alarm_wr model_alarm0=%0d got_alarm=%b required=%b", m_amin[0], o_alarm, exp_alarm());
    end
  endtask

  task automatic test_reset_mid();
    load_time(0, 0);
    run_to(0, 1, 0, 400);
    rst = 1; step(); rst = 0;
    compared++;
    if (o_alarm !== 2'b00 || {o_hour, o_min, o_sec} !== 17'd0) begin
      mismatched++; $display("FAIL reset_in_ring got alarm=%b time=%h required 00/0", o_alarm, {o_hour, o_min, o_sec});
    end
    load_alarm(1, 0, 1);
    load_time(0, 0);
    run_to(0, 1, 0, 400);
    snooze = 1; step();
    run_to(0, 1, 30, 200);
    rst = 1; step(); rst = 0;
    compared++;
    if (o_alarm !== 2'b00 || {o_hour, o_min, o_sec} !== 17'd0) begin
      mismatched++; $display("FAIL reset_in_snooze got alarm=%b time=%h required 00/0", o_alarm, {o_hour, o_min, o_sec});
    end
    // Cleared alarms both sit at 00:00, so a midnight rollover rings both.
    alarm_en = 2'b11;
    load_time(23, 59);
    run_to(0, 0, 0, 400);
    compared++;
    if (o_alarm !== 2'b11) begin mismatched++; $display("FAIL reset_alarm_regs got=%b required=11", o_alarm); end
  endtask

  task automatic test_random();
    ack = 1; step();
    for (int k = 0; k < 6000; k++) begin
      rst = ($urandom % 1500) == 0;
      if ($urandom % 600 == 0) begin
        time_wr = 1;
        wr_hour = ($urandom % 8 == 0) ? 5'(24 + $urandom % 8) : 5'($urandom % 2);
        wr_min  = ($urandom % 8 == 0) ? 6'(60 + $urandom % 4) : 6'($urandom % 4);
      end else if ($urandom % 100 == 0) begin
        alarm_wr  = 1;
        alarm_sel = 3'($urandom % 4);
        wr_hour   = ($urandom % 8 == 0) ? 5'(24 + $urandom % 8) : 5'($urandom % 2);
        wr_min    = ($urandom % 8 == 0) ? 6'(60 + $urandom % 4) : 6'($urandom % 4);
      end
      if ($urandom % 300 == 0) alarm_en = 2'($urandom);
      else if ($urandom % 150 == 0) alarm_en = 2'b11;
      ack    = ($urandom % 250) == 0;
      snooze = ($urandom % 120) == 0;
      step();
      compared++;
      if ({o_hour, o_min, o_sec} !== exp_time() || o_tick !== (m_presc == CLK_HZ - 1) ||
          o_alarm !== exp_alarm() || o_alarm_any !== (|exp_alarm())) begin
        mismatched++;
        $display("FAIL random cycle=%0d got time=%h tick=%b alarm=%b any=%b required time=%h tick=%b alarm=%b",
                 k, {o_hour, o_min, o_sec}, o_tick, o_alarm, o_alarm_any, exp_time(), m_presc == CLK_HZ - 1, exp_alarm());
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; time_wr = 0; alarm_wr = 0; ack = 0; snooze = 0;
    alarm_sel = 3'd0; wr_hour = 5'd0; wr_min = 6'd0; alarm_en = '0;
    test_reset();
    test_prescale();
    test_rollover();
    test_alarm_ring();
    test_snooze();
    test_ack_snooze();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
